// File: rtl/chan_scan_mux_if.sv
// Channel-select bus between a display controller and chan_scan_mux.
// The controller drives the channel data and selection controls; the mux returns its state.
interface chan_scan_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int CW = $clog2(N);

  logic [N*W-1:0] din;
  logic           step;
  logic           auto_en;
  logic           load_sel;
  logic [CW-1:0]  sel_in;
  logic [W-1:0]   dout;
  logic [CW-1:0]  chan;
  logic           changed;

  modport master (
    output din, step, auto_en, load_sel, sel_in,
    input  dout, chan, changed
  );

  modport slave (
    input  din, step, auto_en, load_sel, sel_in,
    output dout, chan, changed
  );
endinterface

// File: rtl/chan_scan_mux.sv
// Registered N-channel selector. The channel is chosen by direct load, by a push-button step,
// or by an auto-scan timer.
module chan_scan_mux #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  chan_scan_mux_if.slave bus
);
  localparam int            CW   = $clog2(N);
  localparam int            PW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW:0]   NLIM = (CW + 1)'(N);
  localparam logic [PW-1:0] PTOP = PW'(SCAN_DIV - 1);

  logic          s1_q, s2_q, s3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          upd_q, changed_q;
  logic [W-1:0]  dout_q, dout_d;

  logic          step_pulse;
  logic          tick;
  logic          load_ok;
  logic          chan_upd;
  logic [CW-1:0] chan_inc;

  always_comb begin
    step_pulse = s2_q & ~s3_q;
    tick       = bus.auto_en && (presc_q == PTOP);
    load_ok    = bus.load_sel && ({1'b0, bus.sel_in} < NLIM);
    chan_inc   = (chan_q == LAST) ? '0 : chan_q + 1'b1;

    // An out-of-range load still wins priority, so it swallows step/tick in that cycle.
    chan_d = chan_q;
    if (bus.load_sel) begin
      if (load_ok) chan_d = bus.sel_in;
    end else if (step_pulse || tick) begin
      chan_d = chan_inc;
    end
    chan_upd = (chan_d != chan_q);

    presc_d = presc_q + 1'b1;
    if (!bus.auto_en || bus.load_sel || step_pulse || tick) presc_d = '0;

    dout_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (chan_q == CW'(k)) dout_d = bus.din[k*W +: W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      presc_q   <= '0;
      chan_q    <= '0;
      upd_q     <= 1'b0;
      changed_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      s1_q      <= bus.step;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      presc_q   <= presc_d;
      chan_q    <= chan_d;
      upd_q     <= chan_upd;
      changed_q <= upd_q;
      dout_q    <= dout_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.chan    = chan_q;
  assign bus.changed = changed_q;
endmodule
